// File: rtl/ddr_wr_arbiter.sv
// ddr_wr_arbiter
// Two-requester round-robin arbiter for the single DDR write port. Requester 0 is the
// HDMI capture path, requester 1 a second frame writer. The winner's burst length,
// address and data are latched and the controller's wr_req / wr_busy / wr_done
// handshake is sequenced. A watchdog aborts a burst whose wr_done never arrives.
//
// Ports
//   ddr_clk, rstn           clock, synchronous active-low reset
//   init_done               DDR calibration complete; gates new grants
//   req0/1                  level requests, held until done/err
//   awlen0/1, waddr0/1,     per-requester burst length, address, data
//   wdata0/1
//   gnt0/1                  high while that requester owns the port
//   done0/1, err0/1         one-cycle completion / watchdog-abort pulses
//   wr_busy, wr_done        controller status and burst-complete pulse
//   wr_req                  write request to the controller
//   awlen, ddr_waddr,       latched burst parameters
//   ddr_wdata
//   timeout_flag            sticky watchdog-abort indicator
//   gnt_cnt0/1              completed bursts per requester (wrapping)
//
// ADDR_W / DATA_W default to CTRL_ADDR_WIDTH (28) and MEM_DQ_WIDTH*8 (16*8) of the
// controller build; override them at instantiation for other memory configurations.

module ddr_wr_arbiter #(
    parameter int unsigned ADDR_W  = 28,
    parameter int unsigned DATA_W  = 128,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic              ddr_clk,
    input  logic              rstn,
    input  logic              init_done,

    input  logic              req0,
    input  logic [3:0]        awlen0,
    input  logic [ADDR_W-1:0] waddr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic [3:0]        awlen1,
    input  logic [ADDR_W-1:0] waddr1,
    input  logic [DATA_W-1:0] wdata1,

    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic              err0,
    output logic              err1,

    input  logic              wr_busy,
    input  logic              wr_done,
    output logic              wr_req,
    output logic [3:0]        awlen,
    output logic [ADDR_W-1:0] ddr_waddr,
    output logic [DATA_W-1:0] ddr_wdata,

    output logic              timeout_flag,
    output logic [15:0]       gnt_cnt0,
    output logic [15:0]       gnt_cnt1
);

    typedef enum logic [3:0] {
        StIdle    = 4'b0001,
        StIssue   = 4'b0010,
        StWait    = 4'b0100,
        StRelease = 4'b1000
    } state_e;

    localparam logic [10:0] TimeoutCnt = 11'(TIMEOUT);

    state_e      state_q;
    logic        rr_q;     // priority pointer when both request: 0 -> req0
    logic        owner_q;  // requester currently holding the port
    logic [10:0] wdog_q;   // cycles spent in ISSUE + WAIT

    logic win_sel;
    logic start;

    // Single request wins outright; a tie is broken by the pointer.
    always_comb begin
        win_sel = (req0 & req1) ? rr_q : req1;
        start   = init_done & ~wr_busy & (req0 | req1);
    end

    always_ff @(posedge ddr_clk) begin
        if (!rstn) begin
            state_q      <= StIdle;
            rr_q         <= 1'b0;
            owner_q      <= 1'b0;
            wdog_q       <= '0;
            gnt0         <= 1'b0;
            gnt1         <= 1'b0;
            done0        <= 1'b0;
            done1        <= 1'b0;
            err0         <= 1'b0;
            err1         <= 1'b0;
            wr_req       <= 1'b0;
            awlen        <= '0;
            ddr_waddr    <= '0;
            ddr_wdata    <= '0;
            timeout_flag <= 1'b0;
            gnt_cnt0     <= '0;
            gnt_cnt1     <= '0;
        end else begin
            // Pulses last exactly one cycle.
            done0 <= 1'b0;
            done1 <= 1'b0;
            err0  <= 1'b0;
            err1  <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        owner_q   <= win_sel;
                        gnt0      <= ~win_sel;
                        gnt1      <= win_sel;
                        awlen     <= win_sel ? awlen1 : awlen0;
                        ddr_waddr <= win_sel ? waddr1 : waddr0;
                        ddr_wdata <= win_sel ? wdata1 : wdata0;
                        wdog_q    <= '0;
                        state_q   <= StIssue;
                    end
                end

                StIssue: begin
                    wr_req  <= 1'b1;
                    wdog_q  <= wdog_q + 11'd1;
                    state_q <= StWait;
                end

                StWait: begin
                    // A wr_done arriving on the expiry cycle still counts as a completion.
                    if (wr_done) begin
                        wr_req  <= 1'b0;
                        rr_q    <= ~owner_q;
                        state_q <= StRelease;
                        if (owner_q) begin
                            done1    <= 1'b1;
                            gnt_cnt1 <= gnt_cnt1 + 16'd1;
                        end else begin
                            done0    <= 1'b1;
                            gnt_cnt0 <= gnt_cnt0 + 16'd1;
                        end
                    end else if (wdog_q >= TimeoutCnt) begin
                        wr_req       <= 1'b0;
                        rr_q         <= ~owner_q;
                        timeout_flag <= 1'b1;
                        state_q      <= StRelease;
                        if (owner_q) begin
                            err1 <= 1'b1;
                        end else begin
                            err0 <= 1'b1;
                        end
                    end else begin
                        wdog_q <= wdog_q + 11'd1;
                    end
                end

                StRelease: begin
                    // One dead cycle so the requester can drop req before re-arbitration.
                    gnt0    <= 1'b0;
                    gnt1    <= 1'b0;
                    state_q <= StIdle;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_wr_arbiter.sv
// Randomized self-checking bench for ddr_wr_arbiter. The reference model tracks each
// burst by timestamps (grant cycle, end cycle) and derives every expected output from
// the documented cycle relationships.

module tb_ddr_wr_arbiter;

    localparam int unsigned ADDR_W  = 28;
    localparam int unsigned DATA_W  = 64;
    localparam int unsigned TIMEOUT = 16;
    localparam int          NCYC    = 3000;

    logic              ddr_clk;
    logic              rstn;
    logic              init_done;
    logic              req0, req1;
    logic [3:0]        awlen0, awlen1;
    logic [ADDR_W-1:0] waddr0, waddr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              gnt0, gnt1, done0, done1, err0, err1;
    logic              wr_busy, wr_done, wr_req;
    logic [3:0]        awlen;
    logic [ADDR_W-1:0] ddr_waddr;
    logic [DATA_W-1:0] ddr_wdata;
    logic              timeout_flag;
    logic [15:0]       gnt_cnt0, gnt_cnt1;

    ddr_wr_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .ddr_clk      (ddr_clk),
        .rstn         (rstn),
        .init_done    (init_done),
        .req0         (req0),
        .awlen0       (awlen0),
        .waddr0       (waddr0),
        .wdata0       (wdata0),
        .req1         (req1),
        .awlen1       (awlen1),
        .waddr1       (waddr1),
        .wdata1       (wdata1),
        .gnt0         (gnt0),
        .gnt1         (gnt1),
        .done0        (done0),
        .done1        (done1),
        .err0         (err0),
        .err1         (err1),
        .wr_busy      (wr_busy),
        .wr_done      (wr_done),
        .wr_req       (wr_req),
        .awlen        (awlen),
        .ddr_waddr    (ddr_waddr),
        .ddr_wdata    (ddr_wdata),
        .timeout_flag (timeout_flag),
        .gnt_cnt0     (gnt_cnt0),
        .gnt_cnt1     (gnt_cnt1)
    );

    initial ddr_clk = 1'b0;
    always #5 ddr_clk = ~ddr_clk;

    int cyc;
    int n_checks;
    int n_fail;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    // Reference model: one burst at a time, described by when it was granted and when
    // its done/err pulse appears (-1 while still outstanding).
    bit                m_active, m_owner, m_aborted, m_rr, m_tflag;
    int                m_tgnt, m_tend, m_done_at;
    logic [15:0]       m_cnt [2];
    logic [3:0]        m_awlen;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_data;

    // Requester-side stimulus state.
    logic              r_req   [2];
    logic [3:0]        r_awlen [2];
    logic [ADDR_W-1:0] r_addr  [2];
    logic [DATA_W-1:0] r_data  [2];

    task automatic model_reset();
        m_active  = 1'b0;
        m_owner   = 1'b0;
        m_aborted = 1'b0;
        m_rr      = 1'b0;
        m_tflag   = 1'b0;
        m_tgnt    = 0;
        m_tend    = -1;
        m_done_at = -1;
        m_cnt[0]  = '0;
        m_cnt[1]  = '0;
        m_awlen   = '0;
        m_addr    = '0;
        m_data    = '0;
    endtask

    task automatic new_payload(input int x);
        r_awlen[x] = 4'($urandom);
        r_addr[x]  = ADDR_W'($urandom);
        r_data[x]  = {$urandom, $urandom};
    endtask

    initial begin
        bit in_burst, in_wait, free, win, rst0_done, rst1_done;
        logic exp_wrreq;

        n_checks  = 0;
        n_fail    = 0;
        cyc       = 0;
        rst0_done = 1'b0;
        rst1_done = 1'b0;
        model_reset();
        for (int x = 0; x < 2; x++) begin
            r_req[x] = 1'b0;
            new_payload(x);
        end
        rstn      = 1'b0;
        init_done = 1'b0;
        wr_busy   = 1'b0;
        wr_done   = 1'b0;
        req0 = 1'b0; awlen0 = r_awlen[0]; waddr0 = r_addr[0]; wdata0 = r_data[0];
        req1 = 1'b0; awlen1 = r_awlen[1]; waddr1 = r_addr[1]; wdata1 = r_data[1];
        repeat (2) @(posedge ddr_clk);

        for (int i = 0; i < NCYC; i++) begin
            @(negedge ddr_clk);

            // Expected outputs for this cycle.
            in_burst  = m_active && (m_tend < 0 || cyc <= m_tend);
            exp_wrreq = m_active && (cyc >= m_tgnt + 1) && (m_tend < 0 || cyc < m_tend);
            check_eq("gnt0", 64'(gnt0), 64'(in_burst && !m_owner));
            check_eq("gnt1", 64'(gnt1), 64'(in_burst && m_owner));
            check_eq("wr_req", 64'(wr_req), 64'(exp_wrreq));
            check_eq("done0", 64'(done0), 64'(m_active && m_tend == cyc && !m_aborted && !m_owner));
            check_eq("done1", 64'(done1), 64'(m_active && m_tend == cyc && !m_aborted && m_owner));
            check_eq("err0", 64'(err0), 64'(m_active && m_tend == cyc && m_aborted && !m_owner));
            check_eq("err1", 64'(err1), 64'(m_active && m_tend == cyc && m_aborted && m_owner));
            check_eq("awlen", 64'(awlen), 64'(m_awlen));
            check_eq("ddr_waddr", 64'(ddr_waddr), 64'(m_addr));
            check_eq("ddr_wdata", 64'(ddr_wdata), 64'(m_data));
            check_eq("timeout_flag", 64'(timeout_flag), 64'(m_tflag));
            check_eq("gnt_cnt0", 64'(gnt_cnt0), 64'(m_cnt[0]));
            check_eq("gnt_cnt1", 64'(gnt_cnt1), 64'(m_cnt[1]));

            // Stimulus for this cycle.
            in_wait = m_active && m_tend < 0 && cyc >= m_tgnt + 1;
            rstn = 1'b1;
            if (in_wait && cyc >= 800 && !rst0_done) begin
                rstn = 1'b0;
                rst0_done = 1'b1;
            end else if (in_wait && cyc >= 1900 && !rst1_done) begin
                rstn = 1'b0;
                rst1_done = 1'b1;
            end
            init_done = (cyc >= 300 && cyc < 330) ? 1'b0 : ($urandom_range(0, 9) != 0);
            wr_busy   = ($urandom_range(0, 4) == 0);
            // Stray wr_done only outside WAIT, where it must be ignored.
            wr_done   = in_wait ? (cyc == m_done_at) : ($urandom_range(0, 19) == 0);

            for (int x = 0; x < 2; x++) begin
                if (m_active && m_tend == cyc && int'(m_owner) == x) begin
                    r_req[x] = 1'b0;
                end else if (!r_req[x]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        r_req[x] = 1'b1;
                        new_payload(x);
                    end
                end else if ($urandom_range(0, 1) == 0) begin
                    new_payload(x);
                end
            end
            req0 = r_req[0]; awlen0 = r_awlen[0]; waddr0 = r_addr[0]; wdata0 = r_data[0];
            req1 = r_req[1]; awlen1 = r_awlen[1]; waddr1 = r_addr[1]; wdata1 = r_data[1];

            // Model reaction to this cycle's inputs, visible from the next cycle.
            free = !m_active || (m_tend >= 0 && cyc > m_tend);
            if (!rstn) begin
                model_reset();
            end else if (in_wait) begin
                if (wr_done) begin
                    m_tend    = cyc + 1;
                    m_aborted = 1'b0;
                    m_cnt[m_owner] = m_cnt[m_owner] + 16'd1;
                    m_rr      = !m_owner;
                end else if (cyc == m_tgnt + int'(TIMEOUT)) begin
                    m_tend    = cyc + 1;
                    m_aborted = 1'b1;
                    m_tflag   = 1'b1;
                    m_rr      = !m_owner;
                end
            end else if (free && init_done && !wr_busy && (r_req[0] || r_req[1])) begin
                win       = (r_req[0] && r_req[1]) ? m_rr : r_req[1];
                m_active  = 1'b1;
                m_owner   = win;
                m_aborted = 1'b0;
                m_tgnt    = cyc + 1;
                m_tend    = -1;
                m_awlen   = r_awlen[win];
                m_addr    = r_addr[win];
                m_data    = r_data[win];
                // Sometimes withhold wr_done entirely so the watchdog fires.
                m_done_at = ($urandom_range(0, 6) == 0) ? -1 :
                            m_tgnt + int'($urandom_range(1, 10));
            end

            @(posedge ddr_clk);
            cyc++;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
